gray2bin_tracker: RTL and testbench

Registered Gray-to-binary decoder with step checking, the receive-side counterpart of the team's binary-to-Gray encoder. Accepts a stream of WIDTH-bit Gray codes over a valid/ready handshake, converts each to binary, compares it to the previous sample to report count direction, and flags any sample that is not a legal single-step move. Sits at the consumer end of Gray-coded links: pointer crossings, position sensors and encoded counters.

---
 rtl/gray2bin_tracker_if.sv | 26 ++
 rtl/gray2bin_tracker.sv | 102 ++++++++++
 tb/tb_gray2bin_tracker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gray2bin_tracker_if.sv
// rtl/gray2bin_tracker_if.sv - handshake bundle for the Gray-to-binary step tracker
interface gray2bin_tracker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_out;
  logic             dir_up;
  logic             step_err;
  logic             out_valid;
  logic             out_ready;
  logic             clr_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output gray_in, in_valid, out_ready, clr_err,
    input  in_ready, bin_out, dir_up, step_err, out_valid, err_cnt
  );

  modport slave (
    input  gray_in, in_valid, out_ready, clr_err,
    output in_ready, bin_out, dir_up, step_err, out_valid, err_cnt
  );
endinterface

// File: rtl/gray2bin_tracker.sv
// rtl/gray2bin_tracker.sv - registered Gray-to-binary decoder with single-step checking
module gray2bin_tracker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  gray2bin_tracker_if.slave bus
);
  typedef enum logic {EMPTY, TRACK} state_t;

  localparam logic [WIDTH-1:0] STEP_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DOWN = '1;
  localparam logic [ERR_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             in_ready;
  logic             accept;
  logic             bad_step;

  always_comb begin
    dec = '0;
    dec[WIDTH-1] = bus.gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ bus.gray_in[i];
    end
  end

  assign in_ready = !vld_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // bin_q always holds the last accepted sample, so it doubles as the step reference
  assign delta    = dec - bin_q;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    dir_d    = dir_q;
    err_d    = err_q;
    vld_d    = vld_q;
    bad_step = 1'b0;
    if (accept) begin
      bin_d = dec;
      vld_d = 1'b1;
      err_d = 1'b0;
      if (state_q == EMPTY) begin
        dir_d   = 1'b0;
        state_d = TRACK;
      end else if (delta == STEP_UP) begin
        dir_d = 1'b1;
      end else if (delta == STEP_DOWN) begin
        dir_d = 1'b0;
      end else if (delta != '0) begin
        err_d    = 1'b1;
        bad_step = 1'b1;
      end
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  // A clear coinciding with a new error still records that error
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_err) begin
      cnt_d = bad_step ? ERR_W'(1) : '0;
    end else if (bad_step && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      bin_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.bin_out   = bin_q;
  assign bus.dir_up    = dir_q;
  assign bus.step_err  = err_q;
  assign bus.out_valid = vld_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_gray2bin_tracker.sv
// tb/tb_gray2bin_tracker.sv - table-driven check of gray2bin_tracker
module tb_gray2bin_tracker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray2bin_tracker_if #(.WIDTH(4), .ERR_W(8)) ifa ();
  gray2bin_tracker_if #(.WIDTH(4), .ERR_W(2)) ifb ();

  gray2bin_tracker #(.WIDTH(4), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  gray2bin_tracker #(.WIDTH(4), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    string      nm;
    logic [3:0] g;
    bit         iv;
    bit         ordy;
    bit         clr;
    bit         e_rdy;
    logic [3:0] e_bin;
    bit         e_dir;
    bit         e_err;
    bit         e_vld;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [3:0] g, input bit iv, input bit ordy,
                              input bit clr, input bit e_rdy, input logic [3:0] e_bin,
                              input bit e_dir, input bit e_err, input bit e_vld, input logic [7:0] e_cnt);
    vec_t v;
    v.nm = nm; v.g = g; v.iv = iv; v.ordy = ordy; v.clr = clr; v.e_rdy = e_rdy;
    v.e_bin = e_bin; v.e_dir = e_dir; v.e_err = e_err; v.e_vld = e_vld; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic apply_a(input vec_t v);
    ifa.gray_in   = v.g;
    ifa.in_valid  = v.iv;
    ifa.out_ready = v.ordy;
    ifa.clr_err   = v.clr;
    #1;
    chk({v.nm, ".in_ready"}, 32'(ifa.in_ready), 32'(v.e_rdy));
    @(negedge clk);
    chk({v.nm, ".bin_out"},   32'(ifa.bin_out),   32'(v.e_bin));
    chk({v.nm, ".dir_up"},    32'(ifa.dir_up),    32'(v.e_dir));
    chk({v.nm, ".step_err"},  32'(ifa.step_err),  32'(v.e_err));
    chk({v.nm, ".out_valid"}, 32'(ifa.out_valid), 32'(v.e_vld));
    chk({v.nm, ".err_cnt"},   32'(ifa.err_cnt),   32'(v.e_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    for (int i = 0; i < 16; i++) begin
      g = 4'(i ^ (i >> 1));
      add($sformatf("exh%0d", i), g, 1, 1, 0, 1, 4'(i), i > 0, 0, 1, 8'd0);
    end
    add("wrap_up",   4'b0000, 1, 1, 0, 1, 4'd0,  1, 0, 1, 8'd0);
    add("wrap_down", 4'b1000, 1, 1, 0, 1, 4'd15, 0, 0, 1, 8'd0);
    add("ill_pre",   4'b0000, 1, 1, 0, 1, 4'd0,  1, 0, 1, 8'd0);
    add("ill_step",  4'b0110, 1, 1, 0, 1, 4'd4,  1, 1, 1, 8'd1);
    add("ill_resync",4'b0111, 1, 1, 0, 1, 4'd5,  1, 0, 1, 8'd1);
    for (int i = 0; i < 3; i++)
      add($sformatf("bp_hold%0d", i), 4'b0101, 1, 0, 0, 0, 4'd5, 1, 0, 1, 8'd1);
    add("bp_release", 4'b0101, 1, 1, 0, 1, 4'd6, 1, 0, 1, 8'd1);
    add("drain",      4'b0000, 0, 1, 0, 1, 4'd6, 1, 0, 0, 8'd1);
    add("idle_hold",  4'b0000, 0, 0, 0, 1, 4'd6, 1, 0, 0, 8'd1);
    add("pend_load",  4'b0100, 1, 0, 0, 1, 4'd7, 1, 0, 1, 8'd1);
    add("pend_stall", 4'b0100, 0, 0, 0, 0, 4'd7, 1, 0, 1, 8'd1);

    ifa.gray_in = '0; ifa.in_valid = 0; ifa.out_ready = 0; ifa.clr_err = 0;
    ifb.gray_in = '0; ifb.in_valid = 0; ifb.out_ready = 0; ifb.clr_err = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(ifa.out_valid), 0);
    chk("rst.bin_out",   32'(ifa.bin_out),   0);
    chk("rst.dir_up",    32'(ifa.dir_up),    0);
    chk("rst.step_err",  32'(ifa.step_err),  0);
    chk("rst.err_cnt",   32'(ifa.err_cnt),   0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready",  32'(ifa.in_ready),  1);

    foreach (vecs[i]) apply_a(vecs[i]);

    // reset while an output is pending and stalled
    rst = 1'b1;
    ifa.gray_in = 4'b0101; ifa.in_valid = 1; ifa.out_ready = 0;
    @(negedge clk);
    chk("mid_rst.out_valid", 32'(ifa.out_valid), 0);
    chk("mid_rst.bin_out",   32'(ifa.bin_out),   0);
    chk("mid_rst.dir_up",    32'(ifa.dir_up),    0);
    chk("mid_rst.step_err",  32'(ifa.step_err),  0);
    chk("mid_rst.err_cnt",   32'(ifa.err_cnt),   0);
    rst = 1'b0;
    ifa.in_valid = 0;
    #1;
    chk("mid_rst.in_ready",  32'(ifa.in_ready),  1);
    ifa.gray_in = 4'b0010; ifa.in_valid = 1; ifa.out_ready = 1;
    @(negedge clk);
    chk("first_after_rst.bin_out",   32'(ifa.bin_out),   3);
    chk("first_after_rst.step_err",  32'(ifa.step_err),  0);
    chk("first_after_rst.dir_up",    32'(ifa.dir_up),    0);
    chk("first_after_rst.out_valid", 32'(ifa.out_valid), 1);
    chk("first_after_rst.err_cnt",   32'(ifa.err_cnt),   0);
    ifa.in_valid = 0;

    // saturation and clear on the 2-bit counter instance
    ifb.gray_in = 4'b0000; ifb.in_valid = 1; ifb.out_ready = 1;
    @(negedge clk);
    chk("sat_ref.err_cnt", 32'(ifb.err_cnt), 0);
    for (int k = 0; k < 5; k++) begin
      ifb.gray_in = (k % 2 == 0) ? 4'b0110 : 4'b0000;
      @(negedge clk);
      chk($sformatf("sat%0d.step_err", k), 32'(ifb.step_err), 1);
      chk($sformatf("sat%0d.err_cnt", k),  32'(ifb.err_cnt),  32'(sat_exp[k]));
    end
    ifb.gray_in = 4'b0000; ifb.clr_err = 1;
    @(negedge clk);
    chk("clr_with_err.err_cnt", 32'(ifb.err_cnt), 1);
    ifb.in_valid = 0;
    @(negedge clk);
    chk("clr_alone.err_cnt", 32'(ifb.err_cnt), 0);
    ifb.clr_err = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
